// File: rtl/axi_cpu_master_bridge.sv
// CPU single-access request port to single-beat AXI4 master (LEN=0, INCR), one transaction in flight.
// Optional build macro AXI_BRIDGE_POSTED_WRITE_EN: writes complete at AW+W acceptance and B errors go to wr_err_sticky.
`timescale 1ns/1ps

module axi_cpu_master_bridge #(
    parameter int                 ID_BITS   = 4,
    parameter logic [ID_BITS-1:0] MASTER_ID = '0,
    parameter int                 ADDR_BITS = 32,
    parameter int                 DATA_BITS = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,

    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_BITS-1:0]   cpu_addr,
    input  logic [2:0]             cpu_size,
    input  logic [DATA_BITS/8-1:0] cpu_wstrb,
    input  logic [DATA_BITS-1:0]   cpu_wdata,
    output logic [DATA_BITS-1:0]   cpu_rdata,
    output logic                   cpu_done,
    output logic                   cpu_err,
    output logic                   cpu_stall,

    output logic [ID_BITS-1:0]     AWID,
    output logic [ADDR_BITS-1:0]   AWADDR,
    output logic [7:0]             AWLEN,
    output logic [2:0]             AWSIZE,
    output logic [1:0]             AWBURST,
    output logic                   AWVALID,
    input  logic                   AWREADY,

    output logic [DATA_BITS-1:0]   WDATA,
    output logic [DATA_BITS/8-1:0] WSTRB,
    output logic                   WLAST,
    output logic                   WVALID,
    input  logic                   WREADY,

    input  logic [ID_BITS-1:0]     BID,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY,

    output logic [ID_BITS-1:0]     ARID,
    output logic [ADDR_BITS-1:0]   ARADDR,
    output logic [7:0]             ARLEN,
    output logic [2:0]             ARSIZE,
    output logic [1:0]             ARBURST,
    output logic                   ARVALID,
    input  logic                   ARREADY,

    input  logic [ID_BITS-1:0]     RID,
    input  logic [DATA_BITS-1:0]   RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RLAST,
    input  logic                   RVALID,
    output logic                   RREADY
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
    ,
    output logic                   wr_err_sticky
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [2:0]             r_size;
    logic [DATA_BITS-1:0]   r_wdata;
    logic [DATA_BITS/8-1:0] r_wstrb;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_arvalid;
    logic                   r_rready;
    logic                   r_bready;
    logic                   r_aw_acc;
    logic                   r_w_acc;
    logic                   r_abandon;
    logic                   r_done;
    logic                   r_err;
    logic [DATA_BITS-1:0]   r_rdata;
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
    logic                   r_wr_err_sticky;
`endif

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_b_hs;
    logic w_deliver;
    logic w_unused;

    assign w_aw_hs   = r_awvalid & AWREADY;
    assign w_w_hs    = r_wvalid & WREADY;
    assign w_aw_ok   = r_aw_acc | w_aw_hs;
    assign w_w_ok    = r_w_acc | w_w_hs;
    assign w_ar_hs   = r_arvalid & ARREADY;
    assign w_r_hs    = r_rready & RVALID;
    assign w_b_hs    = r_bready & BVALID;
    // A request dropped at any point of the transaction forfeits its completion.
    assign w_deliver = ~r_abandon & cpu_req;
    assign w_unused  = ^{BID, RID, RLAST};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_size          <= '0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_arvalid       <= 1'b0;
            r_rready        <= 1'b0;
            r_bready        <= 1'b0;
            r_aw_acc        <= 1'b0;
            r_w_acc         <= 1'b0;
            r_abandon       <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
            r_wr_err_sticky <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr    <= cpu_addr;
                        r_size    <= cpu_size;
                        r_wdata   <= cpu_wdata;
                        r_wstrb   <= cpu_wstrb;
                        r_abandon <= 1'b0;
                        r_aw_acc  <= 1'b0;
                        r_w_acc   <= 1'b0;
                        if (cpu_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_ADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end

                S_RD_ADDR: begin
                    if (!cpu_req)
                        r_abandon <= 1'b1;
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (!cpu_req)
                        r_abandon <= 1'b1;
                    // Any accepted beat is final, whatever RLAST says.
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        if (w_deliver) begin
                            r_rdata <= RDATA;
                            r_err   <= (RRESP != 2'b00);
                            r_done  <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end

                S_WR_ADDR: begin
                    if (!cpu_req)
                        r_abandon <= 1'b1;
                    if (w_aw_hs)
                        r_awvalid <= 1'b0;
                    if (w_w_hs)
                        r_wvalid <= 1'b0;
                    // AW and W may be accepted in either order or together.
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_acc <= 1'b0;
                        r_w_acc  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
                        if (w_deliver) begin
                            r_err  <= 1'b0;
                            r_done <= 1'b1;
                        end
`endif
                    end else begin
                        r_aw_acc <= w_aw_ok;
                        r_w_acc  <= w_w_ok;
                    end
                end

                S_WR_RESP: begin
`ifndef AXI_BRIDGE_POSTED_WRITE_EN
                    if (!cpu_req)
                        r_abandon <= 1'b1;
`endif
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_state  <= S_DONE;
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
                        if (BRESP != 2'b00)
                            r_wr_err_sticky <= 1'b1;
`else
                        if (w_deliver) begin
                            r_err  <= (BRESP != 2'b00);
                            r_done <= 1'b1;
                        end
`endif
                    end
                end

                // Gap cycle so the CPU can drop cpu_req before IDLE samples it.
                S_DONE: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AWID    = MASTER_ID;
    assign AWADDR  = r_addr;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = r_size;
    assign AWBURST = 2'b01;
    assign AWVALID = r_awvalid;

    assign WDATA   = r_wdata;
    assign WSTRB   = r_wstrb;
    assign WLAST   = 1'b1;
    assign WVALID  = r_wvalid;

    assign BREADY  = r_bready;

    assign ARID    = MASTER_ID;
    assign ARADDR  = r_addr;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = r_size;
    assign ARBURST = 2'b01;
    assign ARVALID = r_arvalid;

    assign RREADY  = r_rready;

    assign cpu_rdata = r_rdata;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign cpu_stall = cpu_req & ~r_done;

`ifdef AXI_BRIDGE_POSTED_WRITE_EN
    assign wr_err_sticky = r_wr_err_sticky;
`endif

endmodule

// File: tb/tb_axi_cpu_master_bridge.sv
// Directed bench for axi_cpu_master_bridge (default build): hand-driven AXI slave, inline checks per scenario.
`timescale 1ns/1ps

module tb_axi_cpu_master_bridge;

    logic        ACLK;
    logic        ARESETn;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [2:0]  cpu_size;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_stall;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int n_cmp = 0;
    int n_mis = 0;

    axi_cpu_master_bridge #(
        .ID_BITS(4), .MASTER_ID(4'h0), .ADDR_BITS(32), .DATA_BITS(32)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_size = '0; cpu_wstrb = '0; cpu_wdata = '0;
        AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
        ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1; RVALID = 0;
    endtask

    // Zero-wait read: returns cycles from request to cpu_done (-1 on timeout).
    task automatic run_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            output int lat, output logic [31:0] rd, output logic er);
        cpu_req = 1; cpu_we = 0; cpu_addr = a; cpu_size = 3'd2; ARREADY = 1; RVALID = 0;
        lat = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            lat++;
            if (cpu_done) begin
                rd = cpu_rdata; er = cpu_err;
                break;
            end
            if (RREADY) begin RVALID = 1; RDATA = d; RRESP = resp; end
            else RVALID = 0;
        end
        if (!cpu_done) lat = -1;
        cpu_req = 0; RVALID = 0; ARREADY = 0;
        @(negedge ACLK);
    endtask

    task automatic test_reset;
        idle_inputs();
        ARESETn = 0;
        @(negedge ACLK);
        cpu_req = 1;
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 5'b0) begin n_mis++; $display("FAIL rst_valids: got %b want 00000", {AWVALID, WVALID, ARVALID, BREADY, RREADY}); end
        n_cmp++; if ({cpu_done, cpu_err} !== 2'b00) begin n_mis++; $display("FAIL rst_done_err: got %b want 00", {cpu_done, cpu_err}); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_rdata: got %h want 00000000", cpu_rdata); end
        n_cmp++; if ({AWLEN, ARLEN} !== 16'h0) begin n_mis++; $display("FAIL rst_len: got %h want 0000", {AWLEN, ARLEN}); end
        n_cmp++; if ({AWBURST, ARBURST, WLAST} !== 5'b01011) begin n_mis++; $display("FAIL rst_burst_wlast: got %b want 01011", {AWBURST, ARBURST, WLAST}); end
        n_cmp++; if ({AWID, ARID} !== 8'h00) begin n_mis++; $display("FAIL rst_ids: got %h want 00", {AWID, ARID}); end
        cpu_req = 0;
        ARESETn = 1;
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID, ARVALID} !== 3'b0) begin n_mis++; $display("FAIL rst_release_idle: got %b want 000", {AWVALID, WVALID, ARVALID}); end
        $display("reset: released, outputs idle");
    endtask

    task automatic test_read_basic;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0001_0004; cpu_size = 3'd2; ARREADY = 1;
        @(negedge ACLK);
        n_cmp++; if (ARVALID !== 1'b1) begin n_mis++; $display("FAIL rd_arvalid: got %b want 1", ARVALID); end
        n_cmp++; if (ARADDR !== 32'h0001_0004) begin n_mis++; $display("FAIL rd_araddr: got %h want 00010004", ARADDR); end
        n_cmp++; if ({ARSIZE, ARLEN} !== {3'd2, 8'd0}) begin n_mis++; $display("FAIL rd_arsize_len: got %h/%h want 2/00", ARSIZE, ARLEN); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_mis++; $display("FAIL rd_stall: got %b want 1", cpu_stall); end
        @(negedge ACLK);
        n_cmp++; if ({ARVALID, RREADY, cpu_done} !== 3'b010) begin n_mis++; $display("FAIL rd_phase2: got %b want 010", {ARVALID, RREADY, cpu_done}); end
        RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00; ARREADY = 0;
        @(negedge ACLK);
        n_cmp++; if (cpu_done !== 1'b1) begin n_mis++; $display("FAIL rd_done_lat3: got %b want 1", cpu_done); end
        n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL rd_rdata: got %h want deadbeef", cpu_rdata); end
        n_cmp++; if ({cpu_err, cpu_stall, RREADY} !== 3'b000) begin n_mis++; $display("FAIL rd_err_stall_rready: got %b want 000", {cpu_err, cpu_stall, RREADY}); end
        cpu_req = 0; RVALID = 0;
        @(negedge ACLK);
        n_cmp++; if (cpu_done !== 1'b0) begin n_mis++; $display("FAIL rd_done_single: got %b want 0", cpu_done); end
        $display("read: addr=00010004 rdata=%h err=%b", cpu_rdata, cpu_err);
    endtask

    task automatic test_write_byte;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0001_0002; cpu_size = 3'd0;
        cpu_wstrb = 4'b0100; cpu_wdata = 32'h00AB_0000; AWREADY = 1; WREADY = 1;
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID, ARVALID} !== 3'b110) begin n_mis++; $display("FAIL wr_valids: got %b want 110", {AWVALID, WVALID, ARVALID}); end
        n_cmp++; if (AWADDR !== 32'h0001_0002) begin n_mis++; $display("FAIL wr_awaddr: got %h want 00010002", AWADDR); end
        n_cmp++; if ({AWSIZE, AWLEN, AWBURST} !== {3'd0, 8'd0, 2'b01}) begin n_mis++; $display("FAIL wr_aw_attr: got %h/%h/%b want 0/00/01", AWSIZE, AWLEN, AWBURST); end
        n_cmp++; if ({WSTRB, WLAST} !== 5'b01001) begin n_mis++; $display("FAIL wr_wstrb_wlast: got %b/%b want 0100/1", WSTRB, WLAST); end
        n_cmp++; if (WDATA !== 32'h00AB_0000) begin n_mis++; $display("FAIL wr_wdata: got %h want 00ab0000", WDATA); end
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID, BREADY, cpu_done} !== 4'b0010) begin n_mis++; $display("FAIL wr_resp_phase: got %b want 0010", {AWVALID, WVALID, BREADY, cpu_done}); end
        AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
        @(negedge ACLK);
        n_cmp++; if ({cpu_done, cpu_err, BREADY} !== 3'b100) begin n_mis++; $display("FAIL wr_done: got %b want 100", {cpu_done, cpu_err, BREADY}); end
        cpu_req = 0; BVALID = 0;
        @(negedge ACLK);
        n_cmp++; if (cpu_done !== 1'b0) begin n_mis++; $display("FAIL wr_done_single: got %b want 0", cpu_done); end
        $display("write: addr=00010002 wstrb=0100 wdata=00ab0000 err=%b", cpu_err);
    endtask

    task automatic test_w_before_aw;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0001_0010; cpu_size = 3'd2;
        cpu_wstrb = 4'hF; cpu_wdata = 32'h1122_3344; AWREADY = 0; WREADY = 1;
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID} !== 2'b11) begin n_mis++; $display("FAIL wfirst_valids: got %b want 11", {AWVALID, WVALID}); end
        cpu_addr = 32'hFFFF_FFF0;
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID, BREADY} !== 3'b100) begin n_mis++; $display("FAIL wfirst_w_dropped: got %b want 100", {AWVALID, WVALID, BREADY}); end
        n_cmp++; if (AWADDR !== 32'h0001_0010) begin n_mis++; $display("FAIL wfirst_awaddr_stable: got %h want 00010010", AWADDR); end
        WREADY = 0; AWREADY = 1;
        @(negedge ACLK);
        n_cmp++; if ({AWVALID, WVALID, BREADY, cpu_done} !== 4'b0010) begin n_mis++; $display("FAIL wfirst_resp_phase: got %b want 0010", {AWVALID, WVALID, BREADY, cpu_done}); end
        AWREADY = 0; BVALID = 1; BRESP = 2'b00;
        @(negedge ACLK);
        n_cmp++; if ({cpu_done, cpu_err, BREADY} !== 3'b100) begin n_mis++; $display("FAIL wfirst_done: got %b want 100", {cpu_done, cpu_err, BREADY}); end
        cpu_req = 0;
        @(negedge ACLK);
        n_cmp++; if ({BREADY, cpu_done, AWVALID, WVALID} !== 4'b0000) begin n_mis++; $display("FAIL wfirst_one_b: got %b want 0000", {BREADY, cpu_done, AWVALID, WVALID}); end
        BVALID = 0;
        $display("write w-before-aw: addr=00010010 err=%b", cpu_err);
    endtask

    task automatic test_error_resp;
        int          lat;
        logic [31:0] rd;
        logic        er;
        run_read(32'h0000_0080, 32'h1234_5678, 2'b10, lat, rd, er);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL err_lat: got %0d want 3", lat); end
        n_cmp++; if ({rd, er} !== {32'h1234_5678, 1'b1}) begin n_mis++; $display("FAIL err_slverr: got %h/%b want 12345678/1", rd, er); end
        $display("read slverr: rdata=%h err=%b", rd, er);
        run_read(32'h0000_0084, 32'h0F0F_0F0F, 2'b00, lat, rd, er);
        n_cmp++; if ({rd, er} !== {32'h0F0F_0F0F, 1'b0}) begin n_mis++; $display("FAIL err_then_okay: got %h/%b want 0f0f0f0f/0", rd, er); end
        $display("read okay: rdata=%h err=%b", rd, er);
    endtask

    task automatic test_ar_wait;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100; cpu_size = 3'd2;
        ARREADY = 0; RVALID = 1; RDATA = 32'hBAD0_BAD0; RRESP = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n_cmp++; if ({ARVALID, RREADY, cpu_done} !== 3'b100 || ARADDR !== 32'h0000_0100) begin
                n_mis++; $display("FAIL arwait_hold_c%0d: got v/rr/d=%b addr=%h want 100 00000100", i, {ARVALID, RREADY, cpu_done}, ARADDR);
            end
        end
        ARREADY = 1; RVALID = 0;
        @(negedge ACLK);
        n_cmp++; if ({ARVALID, RREADY, cpu_done} !== 3'b010) begin n_mis++; $display("FAIL arwait_after_hs: got %b want 010", {ARVALID, RREADY, cpu_done}); end
        ARREADY = 0; RVALID = 1; RDATA = 32'hCAFE_F00D; RLAST = 0;
        @(negedge ACLK);
        n_cmp++; if ({cpu_done, cpu_err, cpu_rdata} !== {2'b10, 32'hCAFE_F00D}) begin n_mis++; $display("FAIL arwait_done: got %b/%h want 10/cafef00d", {cpu_done, cpu_err}, cpu_rdata); end
        cpu_req = 0; RVALID = 0; RLAST = 1;
        @(negedge ACLK);
        $display("read ar-wait: rdata=%h err=%b", cpu_rdata, cpu_err);
    endtask

    task automatic test_req_drop;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0200; cpu_size = 3'd2; ARREADY = 0;
        @(negedge ACLK);
        cpu_req = 0;
        @(negedge ACLK);
        n_cmp++; if ({ARVALID, cpu_stall} !== 2'b10) begin n_mis++; $display("FAIL drop_arvalid_held: got %b want 10", {ARVALID, cpu_stall}); end
        ARREADY = 1;
        @(negedge ACLK);
        n_cmp++; if (RREADY !== 1'b1) begin n_mis++; $display("FAIL drop_rready: got %b want 1", RREADY); end
        ARREADY = 0; RVALID = 1; RDATA = 32'hFFFF_0000; RRESP = 2'b10;
        @(negedge ACLK);
        n_cmp++; if ({cpu_done, RREADY} !== 2'b00) begin n_mis++; $display("FAIL drop_no_done: got %b want 00", {cpu_done, RREADY}); end
        n_cmp++; if ({cpu_rdata, cpu_err} !== {32'hCAFE_F00D, 1'b0}) begin n_mis++; $display("FAIL drop_discard: got %h/%b want cafef00d/0", cpu_rdata, cpu_err); end
        RVALID = 0;
        @(negedge ACLK);
        n_cmp++; if ({cpu_done, ARVALID, RREADY} !== 3'b000) begin n_mis++; $display("FAIL drop_idle: got %b want 000", {cpu_done, ARVALID, RREADY}); end
        $display("read dropped: addr=00000200 discarded");
    endtask

    task automatic test_reset_mid;
        int          lat;
        logic [31:0] rd;
        logic        er;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0300; cpu_size = 3'd2;
        cpu_wstrb = 4'hF; cpu_wdata = 32'hA5A5_A5A5; AWREADY = 1; WREADY = 1;
        @(negedge ACLK);
        @(negedge ACLK);
        n_cmp++; if (BREADY !== 1'b1) begin n_mis++; $display("FAIL rstmid_in_wr_resp: got %b want 1", BREADY); end
        #2 ARESETn = 0;
        #1;
        n_cmp++; if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, cpu_done} !== 6'b0) begin
            n_mis++; $display("FAIL rstmid_async_drop: got %b want 000000", {AWVALID, WVALID, ARVALID, BREADY, RREADY, cpu_done});
        end
        idle_inputs();
        @(negedge ACLK);
        ARESETn = 1;
        run_read(32'h0000_0040, 32'h5A5A_1234, 2'b00, lat, rd, er);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL rstmid_read_lat: got %0d want 3", lat); end
        n_cmp++; if ({rd, er} !== {32'h5A5A_1234, 1'b0}) begin n_mis++; $display("FAIL rstmid_read: got %h/%b want 5a5a1234/0", rd, er); end
        $display("reset mid-write then read: rdata=%h err=%b", rd, er);
    endtask

    initial begin
        idle_inputs();
        ARESETn = 0;
        test_reset();
        test_read_basic();
        test_write_byte();
        test_w_before_aw();
        test_error_resp();
        test_ar_wait();
        test_req_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
